// File: rtl/board_io_ctrl.sv
// Board I/O: key/switch sync and debounce, key events, registered HEX digits.
// Define BOARD_IO_BLINK_EN to build per-digit blinking driven by hex_blink.
module board_io_debounce #(
    parameter int   W         = 1,
    parameter int   DB_CYCLES = 2,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [CW-1:0] cnt [W];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= {W{RST_VAL}};
            s2    <= {W{RST_VAL}};
            level <= {W{RST_VAL}};
            for (int i = 0; i < W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < W; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

module board_io_ctrl #(
    parameter int W_KEY        = 4,
    parameter int W_SW         = 18,
    parameter int N_HEX        = 8,
    parameter int DB_CYCLES    = 500000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W_KEY-1:0]   key_raw,
    input  logic [W_SW-1:0]    sw_raw,
    output logic [W_KEY-1:0]   key_level,
    output logic [W_KEY-1:0]   key_press,
    output logic [W_KEY-1:0]   key_pend,
    input  logic [W_KEY-1:0]   key_pend_clr,
    output logic [W_SW-1:0]    sw_level,
    output logic               sw_change,
    input  logic               hex_we,
    input  logic [4*N_HEX-1:0] hex_wdata,
    input  logic [N_HEX-1:0]   hex_wblank,
    input  logic [N_HEX-1:0]   hex_blink,
    output logic [7*N_HEX-1:0] hex_seg
);
    logic [W_KEY-1:0]   key_stb;
    logic [W_KEY-1:0]   key_lvl_q;
    logic [W_SW-1:0]    sw_q;
    logic [4*N_HEX-1:0] hex_val;
    logic [N_HEX-1:0]   hex_blank;
    logic [N_HEX-1:0]   hex_off;

    // Keys idle high on the board, so their pipeline resets to "released".
    board_io_debounce #(
        .W         (W_KEY),
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (1'b1)
    ) u_key_db (
        .clk   (clk),
        .reset (reset),
        .raw   (key_raw),
        .level (key_stb)
    );

    board_io_debounce #(
        .W         (W_SW),
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (1'b0)
    ) u_sw_db (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_raw),
        .level (sw_level)
    );

    assign key_level = ~key_stb;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_lvl_q <= '0;
            key_press <= '0;
            key_pend  <= '0;
            sw_q      <= '0;
            sw_change <= 1'b0;
        end else begin
            key_lvl_q <= key_level;
            key_press <= key_level & ~key_lvl_q;
            key_pend  <= (key_pend & ~key_pend_clr) | key_press;
            sw_q      <= sw_level;
            sw_change <= |(sw_level ^ sw_q);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef BOARD_IO_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign hex_off = hex_blank | (hex_blink & {N_HEX{blink_off}});
`else
    logic unused_blink;
    assign unused_blink = ^{hex_blink, BLINK_CYCLES[0]};
    assign hex_off      = hex_blank;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_val   <= '0;
            hex_blank <= '1;
            hex_seg   <= '1;
        end else begin
            if (hex_we) begin
                hex_val   <= hex_wdata;
                hex_blank <= hex_wblank;
            end
            for (int d = 0; d < N_HEX; d++) begin
                hex_seg[7*d +: 7] <= hex_off[d] ? 7'h7F
                                   : seg7(hex_val[4*d +: 4]);
            end
        end
    end
endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: directed plan steps, then random traffic vs a model.
// Build with BOARD_IO_BLINK_EN defined to cover the blink path.
module tb_board_io_ctrl;
    localparam int W_KEY = 4;
    localparam int W_SW  = 18;
    localparam int N_HEX = 8;
    localparam int DB    = 4;
    localparam int BLINK = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [W_KEY-1:0]   key_raw, key_level, key_press, key_pend, key_pend_clr;
    logic [W_SW-1:0]    sw_raw, sw_level;
    logic               sw_change, hex_we;
    logic [4*N_HEX-1:0] hex_wdata;
    logic [N_HEX-1:0]   hex_wblank, hex_blink;
    logic [7*N_HEX-1:0] hex_seg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .W_KEY        (W_KEY),
        .W_SW         (W_SW),
        .N_HEX        (N_HEX),
        .DB_CYCLES    (DB),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw      (key_raw),
        .sw_raw       (sw_raw),
        .key_level    (key_level),
        .key_press    (key_press),
        .key_pend     (key_pend),
        .key_pend_clr (key_pend_clr),
        .sw_level     (sw_level),
        .sw_change    (sw_change),
        .hex_we       (hex_we),
        .hex_wdata    (hex_wdata),
        .hex_wblank   (hex_wblank),
        .hex_blink    (hex_blink),
        .hex_seg      (hex_seg)
    );

    // Reference state: synced-value windows, accepted levels, event flags.
    logic [W_KEY-1:0]   m_k1, m_kstb, m_kprev, m_press, m_pend;
    logic [W_KEY-1:0]   m_khist [DB];
    logic [W_SW-1:0]    m_s1, m_sstb, m_sprev;
    logic [W_SW-1:0]    m_shist [DB];
    logic               m_swc;
    logic [4*N_HEX-1:0] m_val;
    logic [N_HEX-1:0]   m_blank;
    logic [7*N_HEX-1:0] m_seg;
    int                 m_n;

    function automatic logic [6:0] hexdig(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [W_KEY-1:0]   kn;
        logic [W_SW-1:0]    sn;
        logic [7*N_HEX-1:0] segn;
        logic               off, flip, ph;
        if (reset) begin
            m_k1 = '1; m_kstb = '1; m_kprev = '0;
            m_press = '0; m_pend = '0;
            m_s1 = '0; m_sstb = '0; m_sprev = '0; m_swc = 1'b0;
            for (int j = 0; j < DB; j++) begin
                m_khist[j] = '1;
                m_shist[j] = '0;
            end
            m_val = '0; m_blank = '1; m_seg = '1; m_n = 0;
            return;
        end
        // A level is accepted once the last DB synced samples all disagree.
        kn = m_kstb;
        for (int i = 0; i < W_KEY; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_khist[j][i] == m_kstb[i]) flip = 1'b0;
            if (flip) kn[i] = ~m_kstb[i];
        end
        sn = m_sstb;
        for (int i = 0; i < W_SW; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_shist[j][i] == m_sstb[i]) flip = 1'b0;
            if (flip) sn[i] = ~m_sstb[i];
        end
        m_pend  = (m_pend & ~key_pend_clr) | m_press;
        m_press = ~m_kstb & ~m_kprev;
        m_kprev = ~m_kstb;
        m_kstb  = kn;
        m_swc   = |(m_sstb ^ m_sprev);
        m_sprev = m_sstb;
        m_sstb  = sn;
        for (int j = DB - 1; j > 0; j--) begin
            m_khist[j] = m_khist[j-1];
            m_shist[j] = m_shist[j-1];
        end
        m_khist[0] = m_k1; m_k1 = key_raw;
        m_shist[0] = m_s1; m_s1 = sw_raw;
        ph = ((m_n / BLINK) % 2) == 1;
        for (int d = 0; d < N_HEX; d++) begin
            off = m_blank[d];
`ifdef BOARD_IO_BLINK_EN
            off = off | (hex_blink[d] & ph);
`else
            off = off | (ph & 1'b0);
`endif
            segn[7*d +: 7] = off ? 7'h7F : hexdig(m_val[4*d +: 4]);
        end
        m_seg = segn;
        if (hex_we) begin
            m_val   = hex_wdata;
            m_blank = hex_wblank;
        end
        m_n++;
    endtask

    task automatic tick();
        logic [W_KEY-1:0] el;
        @(posedge clk);
        model_edge();
        #1;
        el = ~m_kstb;
        check("key_level", key_level, el);
        check("key_press", key_press, m_press);
        check("key_pend", key_pend, m_pend);
        check("sw_level", sw_level, m_sstb);
        check("sw_change", sw_change, m_swc);
        check("hex_seg", hex_seg, m_seg);
    endtask

    initial begin
        logic [7*N_HEX-1:0] exp_seg;
        logic [W_KEY-1:0]   seen;
        logic [6:0]         prev;
        int                 cnt, first, idx;

        reset = 1'b1; key_raw = '1; sw_raw = '0; key_pend_clr = '0;
        hex_we = 1'b0; hex_wdata = '0; hex_wblank = '0; hex_blink = '0;
        repeat (3) tick();
        check("rst_seg", hex_seg, {N_HEX{7'h7F}});
        check("rst_key", {key_level, key_press, key_pend}, 12'h000);
        reset = 1'b0;

        key_raw[1] = 1'b0;
        repeat (5) tick();
        check("t1_level_early", key_level[1], 1'b0);
        tick();
        check("t1_level", key_level[1], 1'b1);
        check("t1_press_early", key_press, 4'b0000);
        tick();
        check("t1_press", key_press, 4'b0010);
        tick();
        check("t1_press_once", key_press, 4'b0000);
        check("t1_pend", key_pend, 4'b0010);
        repeat (3) tick();
        check("t1_pend_hold", key_pend, 4'b0010);
        key_pend_clr = 4'b0010;
        tick();
        key_pend_clr = '0;
        check("t1_pend_clr", key_pend, 4'b0000);
        key_raw = '1;
        repeat (10) tick();

        key_raw[2] = 1'b0;
        repeat (3) tick();
        key_raw[2] = 1'b1;
        seen = '0;
        repeat (10) begin
            tick();
            seen = seen | key_level | key_press | key_pend;
        end
        check("t2_glitch", seen, 4'b0000);

        sw_raw = 18'h21;
        repeat (5) tick();
        check("t3_sw_early", sw_level, 18'h0);
        tick();
        check("t3_sw_level", sw_level, 18'h21);
        cnt = 0;
        repeat (5) begin
            tick();
            cnt += int'(sw_change);
        end
        check("t3_sw_pulses", cnt, 1);

        hex_we = 1'b1; hex_wdata = 32'h0000_18AF; hex_wblank = 8'hF0;
        tick();
        hex_we = 1'b0;
        check("t4_seg_early", hex_seg, {N_HEX{7'h7F}});
        tick();
        exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h00, 7'h08, 7'h0E};
        check("t4_seg", hex_seg, exp_seg);

        key_raw[3] = 1'b0;
        repeat (7) tick();
        check("t5_press3", key_press, 4'b1000);
        key_pend_clr = 4'b1000;
        tick();
        key_pend_clr = '0;
        check("t5_set_wins", key_pend[3], 1'b1);
        key_raw = '1;
        repeat (8) tick();
        key_pend_clr = '1;
        tick();
        key_pend_clr = '0;
        check("t5_pend_clr", key_pend, 4'b0000);

        key_raw[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("t5_rst_key", {key_level, key_press, key_pend}, 12'h000);
        check("t5_rst_sw", {sw_level, sw_change}, 19'h0);
        check("t5_rst_seg", hex_seg, {N_HEX{7'h7F}});
        reset = 1'b0;
        first = 0;
        for (int c = 1; c <= DB + 8; c++) begin
            tick();
            if (c == DB + 2) check("t5_rst_level", key_level[0], 1'b1);
            if (key_press[0] && first == 0) first = c;
        end
        check("t5_rst_press_at", first, DB + 3);
        key_raw = '1;
        repeat (8) tick();

        hex_we = 1'b1; hex_wdata = 32'h0000_18AF; hex_wblank = 8'h00;
        hex_blink = 8'h01;
        tick();
        hex_we = 1'b0;
        repeat (2) tick();
        prev = hex_seg[6:0];
        cnt = 0;
        repeat (40) begin
            tick();
            if (hex_seg[6:0] !== prev) cnt++;
            prev = hex_seg[6:0];
        end
`ifdef BOARD_IO_BLINK_EN
        check("t6_blink_toggles", cnt >= 4, 1'b1);
`else
        check("t6_steady", cnt, 0);
`endif
        hex_blink = '0;

        repeat (1500) begin
            if ($urandom_range(7) == 0) begin
                idx = $urandom_range(W_KEY - 1);
                key_raw[idx] = ~key_raw[idx];
            end
            if ($urandom_range(5) == 0) begin
                idx = $urandom_range(W_SW - 1);
                sw_raw[idx] = ~sw_raw[idx];
            end
            key_pend_clr = ($urandom_range(3) == 0) ? W_KEY'($urandom) : '0;
            hex_we     = ($urandom_range(9) == 0);
            hex_wdata  = $urandom;
            hex_wblank = N_HEX'($urandom);
            hex_blink  = N_HEX'($urandom);
            reset      = ($urandom_range(299) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
